// File: rtl/tytra_pipe_pkg.sv
// Shared definitions for the TyTra pipeline-PE driver: FSM encoding, default widths
// and a constant-foldable clog2.
package tytra_pipe_pkg;
  localparam int DEF_N    = 64;
  localparam int DEF_LENW = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tytra_sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push/pop is legal when full.
module tytra_sync_fifo
  import tytra_pipe_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [N-1:0]          din,
  input  logic                  pop,
  output logic [N-1:0]          dout,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pipe_pe_driver.sv
// Initiator for a TyTra PipePE core: issues operand pairs, realigns results to the
// core's fixed latency and buffers them in a credit-protected FIFO.
module pipe_pe_driver
  import tytra_pipe_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int LENW  = DEF_LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N-1:0]    s_in1,
  input  logic [N-1:0]    s_in2,
  output logic            pe_trigger,
  input  logic            pe_cts,
  output logic [N-1:0]    pe_in1,
  output logic [N-1:0]    pe_in2,
  input  logic [N-1:0]    pe_out,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N-1:0]    m_data
);
  localparam int CW = clog2(DEPTH) + 1;

  logic [1:0]      state;
  logic [LENW-1:0] len_q, issued;
  logic [CW-1:0]   in_flight, fifo_count;
  logic [CW:0]     occ;
  logic            credit_ok, accept, capture, fifo_empty, fifo_full;
  logic [LAT:1]    vld_q;
  logic [LAT:0]    vld_pipe;

  // an op holds a credit from acceptance until its result leaves the FIFO
  assign occ       = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok = occ < (CW+1)'(DEPTH);
  assign s_ready   = (state == ST_RUN) & pe_cts & credit_ok;
  assign accept    = s_valid & s_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  assign vld_pipe = {vld_q, pe_trigger};
  assign capture  = vld_pipe[LAT];
  assign m_valid  = ~fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      issued     <= '0;
      pe_trigger <= 1'b0;
      pe_in1     <= '0;
      pe_in2     <= '0;
      vld_q      <= '0;
      in_flight  <= '0;
    end else begin
      pe_trigger <= accept;
      vld_q      <= vld_pipe[LAT-1:0];
      if (accept) begin
        pe_in1 <= s_in1;
        pe_in2 <= s_in2;
      end
      case ({accept, capture})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
      case (state)
        ST_IDLE: if (start) begin
          len_q  <= len;
          issued <= '0;
          state  <= (len == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: if (accept) begin
          issued <= issued + 1'b1;
          if (issued == len_q - 1'b1) state <= ST_DRAIN;
        end
        ST_DRAIN: if (in_flight == '0 && fifo_empty) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  tytra_sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (pe_out),
    .pop   (m_valid & m_ready),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_pipe_pe_driver.sv
// Directed bench for pipe_pe_driver driving a subtracting PE model (LAT=1).
module tb_pipe_pe_driver;
  localparam int N = 64, LAT = 1, DEPTH = 4, LENW = 16;

  logic            clk, rst, start, busy, done;
  logic [LENW-1:0] len;
  logic            s_valid, s_ready, pe_trigger, pe_cts, m_valid, m_ready;
  logic [N-1:0]    s_in1, s_in2, pe_in1, pe_in2, pe_out, m_data;

  pipe_pe_driver #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_in1(s_in1), .s_in2(s_in2),
    .pe_trigger(pe_trigger), .pe_cts(pe_cts), .pe_in1(pe_in1), .pe_in2(pe_in2),
    .pe_out(pe_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ui_sub-style PE, one cycle of latency
  always_ff @(posedge clk) pe_out <= pe_in1 - pe_in2;

  typedef struct { logic [63:0] a; logic [63:0] b; logic [63:0] exp; } vec_t;
  vec_t tab_a[8];
  vec_t tab_b[6];
  vec_t vecs[$];
  logic [63:0] got[$];
  int checks = 0, errors = 0;
  int idx, n_issue, trig_cnt, done_cnt, busy_cnt, cyc, first_pop, last_pop, done_cyc, cts_viol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    idx = 0; n_issue = 0; trig_cnt = 0; done_cnt = 0; busy_cnt = 0;
    cyc = 0; first_pop = -1; last_pop = -1; done_cyc = -1; cts_viol = 0;
    got.delete();
  endtask

  task automatic load(input int which);
    vecs.delete();
    if (which == 0) foreach (tab_a[i]) vecs.push_back(tab_a[i]);
    else            foreach (tab_b[i]) vecs.push_back(tab_b[i]);
  endtask

  // one clock: drive at negedge, observe settled handshakes 1ns later
  task automatic step(input logic cts, input logic mr, input logic st, input logic [LENW-1:0] ln);
    @(negedge clk);
    pe_cts = cts; m_ready = mr; start = st; len = ln;
    if (idx < vecs.size()) begin
      s_valid = 1'b1; s_in1 = vecs[idx].a; s_in2 = vecs[idx].b;
    end else s_valid = 1'b0;
    #1;
    cyc++;
    if (s_valid && s_ready) begin idx++; n_issue++; if (!cts) cts_viol++; end
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (pe_trigger) trig_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
  endtask

  // mode 0: free-running, 1: m_ready low 20 cycles, 2: cts toggles, 3: restart during RUN
  task automatic run_job(input string nm, input int ln, input int mode);
    logic cts, mr, st;
    int d;
    clear_stats();
    step(1'b1, 1'b1, 1'b1, LENW'(ln));
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      cts = 1'b1; mr = 1'b1; st = 1'b0;
      if (mode == 1) mr = (k >= 20);
      if (mode == 2) cts = ~k[0];
      if (mode == 3) st = (k == 2);
      step(cts, mr, st, 3);
      if (mode == 1 && k == 19) begin
        chk({nm, "_issues_stalled"}, n_issue, DEPTH);
        chk({nm, "_sready_stalled"}, s_ready, 0);
        chk({nm, "_mvalid_stalled"}, m_valid, 1);
      end
    end
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_result_cnt"}, got.size(), ln);
    chk({nm, "_trig_cnt"}, trig_cnt, ln);
    chk({nm, "_cts_viol"}, cts_viol, 0);
    chk({nm, "_busy_after"}, busy, 0);
    foreach (got[i])
      if (i < vecs.size()) chk($sformatf("%s_res%0d", nm, i), got[i], vecs[i].exp);
    if (mode == 0) begin
      chk({nm, "_pop_span"}, last_pop - first_pop, ln - 1);
      d = done_cyc - last_pop;
      chk({nm, "_done_after_pop"}, (d >= 1 && d <= 2), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tab_a[i] = '{64'(100 + i), 64'(i), 64'd100};
    tab_b[0] = '{64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    tab_b[1] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    tab_b[2] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF};
    tab_b[3] = '{64'hDEAD_BEEF, 64'hBEEF, 64'hDEAD_0000};
    tab_b[4] = '{64'd1000, 64'd999, 64'd1};
    tab_b[5] = '{64'd0, 64'd0, 64'd0};

    rst = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_in1 = '0; s_in2 = '0;
    pe_cts = 1'b1; m_ready = 1'b1;
    clear_stats();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_trigger", pe_trigger, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_pe_in1", pe_in1, 0);
    chk("rst_pe_in2", pe_in2, 0);
    rst = 1'b1;

    load(0); run_job("stream", 8, 0);
    load(1); run_job("wrap", 6, 0);
    load(0); run_job("backpressure", 8, 1);
    load(0); run_job("cts_toggle", 8, 2);
    load(1); run_job("restart_ignored", 5, 3);

    // zero-length job
    vecs.delete(); clear_stats();
    step(1'b1, 1'b1, 1'b1, 0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 0);
    chk("len0_busy_cycles", busy_cnt, 1);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_trig", trig_cnt, 0);

    // reset with two operations in flight
    load(0); clear_stats();
    step(1'b1, 1'b0, 1'b1, 8);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("pre_rst_issues", n_issue, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sready", s_ready, 0);
    chk("midrst_trigger", pe_trigger, 0);
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_pe_in1", pe_in1, 0);
    @(negedge clk);
    rst = 1'b1;
    vecs.delete(); clear_stats();
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_mvalid", m_valid, 0);
    chk("postrst_results", got.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
